// File: rtl/lcd_write_fsm_pkg.sv
// Shared types and constants for the HD44780-style LCD write engine.
// Holds the FSM state encoding, the power-on init command list and the command codes.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWR_WAIT = 3'd0,
      SETUP    = 3'd1,
      E_HIGH   = 3'd2,
      HOLD     = 3'd3,
      EXEC     = 3'd4,
      IDLE     = 3'd5
   } lcd_state_t;

   localparam int INIT_LEN = 6;

   // Function set (8-bit, 2 lines) three times, display on, clear, entry mode.
   localparam logic [7:0] INIT_CMDS [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   localparam logic [7:0] CLEAR = 8'h01;
   localparam logic [7:0] HOME  = 8'h02;

   // Clear and both home encodings need the long execution wait.
   function automatic logic isLongCmd(input logic cmdRs, input logic [7:0] cmdByte);
      return !cmdRs && (cmdByte == CLEAR || cmdByte == HOME || cmdByte == (HOME | 8'h01));
   endfunction

endpackage

// File: rtl/lcd_write_fsm_if.sv
// Host load/byte inputs and LCD bus outputs of the LCD write engine.
// master = driver of load/data/rs (host or bench), slave = the write engine.
interface lcd_write_fsm_if;
   logic       load;
   logic [7:0] data;
   logic       rs;
   logic       lcd_e;
   logic       lcd_rs;
   logic [7:0] lcd_db;
   logic       busy;
   logic       overflow;

   modport master (
      output load, data, rs,
      input  lcd_e, lcd_rs, lcd_db, busy, overflow
   );

   modport slave (
      input  load, data, rs,
      output lcd_e, lcd_rs, lcd_db, busy, overflow
   );
endinterface

// File: rtl/lcd_write_fsm_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// rise is a single-cycle pulse three clk edges after async_in goes high.
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [2:0] syncReg;
   logic       riseReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         syncReg <= 3'b000;
         riseReg <= 1'b0;
      end else begin
         syncReg <= {syncReg[1:0], async_in};
         riseReg <= syncReg[1] & ~syncReg[2];
      end
   end

   assign rise = riseReg;

endmodule

// File: rtl/lcd_write_fsm.sv
// HD44780-style LCD write engine: power-on init, then host bytes taken from a
// synchronized load event, each driven with setup / enable / hold / exec timing.
module lcd_write_fsm
   import lcd_pkg::*;
#(
   parameter int T_POWERUP   = 40000,
   parameter int T_AS        = 1,
   parameter int T_PW        = 1,
   parameter int T_H         = 1,
   parameter int T_EXEC      = 100,
   parameter int T_EXEC_LONG = 3400
) (
   input  logic           clk,
   input  logic           reset,
   lcd_write_fsm_if.slave bus
);

   localparam int MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
   localparam int MAX_B = (T_EXEC > T_AS) ? T_EXEC : T_AS;
   localparam int MAX_C = (T_PW > T_H) ? T_PW : T_H;
   localparam int MAX_BC = (MAX_B > MAX_C) ? MAX_B : MAX_C;
   localparam int MAX_T = (MAX_A > MAX_BC) ? MAX_A : MAX_BC;
   localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

   localparam logic [CNT_W-1:0] LAST_PWR  = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0] LAST_AS   = CNT_W'(T_AS - 1);
   localparam logic [CNT_W-1:0] LAST_PW   = CNT_W'(T_PW - 1);
   localparam logic [CNT_W-1:0] LAST_H    = CNT_W'(T_H - 1);
   localparam logic [CNT_W-1:0] LAST_EXEC = CNT_W'(T_EXEC - 1);
   localparam logic [CNT_W-1:0] LAST_LONG = CNT_W'(T_EXEC_LONG - 1);
   localparam logic [2:0]       LAST_IDX  = 3'(INIT_LEN - 1);

   lcd_state_t       stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   logic             lcdEReg, lcdENext;
   logic             lcdRsReg, lcdRsNext;
   logic [7:0]       lcdDbReg, lcdDbNext;
   logic             pendValidReg, pendValidNext;
   logic [7:0]       pendDataReg, pendDataNext;
   logic             pendRsReg, pendRsNext;
   logic             overflowReg, overflowNext;
   logic [2:0]       initIdxReg, initIdxNext;
   logic [CNT_W-1:0] execLast;
   logic             ev;

   edge_sync u_edge_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (bus.load),
      .rise     (ev)
   );

   // The bus still holds the byte being executed, so it decides the wait length.
   assign execLast = isLongCmd(lcdRsReg, lcdDbReg) ? LAST_LONG : LAST_EXEC;

   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg     <= PWR_WAIT;
         cntReg       <= '0;
         lcdEReg      <= 1'b0;
         lcdRsReg     <= 1'b0;
         lcdDbReg     <= 8'h00;
         pendValidReg <= 1'b0;
         pendDataReg  <= 8'h00;
         pendRsReg    <= 1'b0;
         overflowReg  <= 1'b0;
         initIdxReg   <= 3'd0;
      end else begin
         stateReg     <= stateNext;
         cntReg       <= cntNext;
         lcdEReg      <= lcdENext;
         lcdRsReg     <= lcdRsNext;
         lcdDbReg     <= lcdDbNext;
         pendValidReg <= pendValidNext;
         pendDataReg  <= pendDataNext;
         pendRsReg    <= pendRsNext;
         overflowReg  <= overflowNext;
         initIdxReg   <= initIdxNext;
      end
   end

   always_comb begin
      stateNext     = stateReg;
      cntNext       = cntReg;
      lcdRsNext     = lcdRsReg;
      lcdDbNext     = lcdDbReg;
      pendValidNext = pendValidReg;
      pendDataNext  = pendDataReg;
      pendRsNext    = pendRsReg;
      overflowNext  = overflowReg;
      initIdxNext   = initIdxReg;

      // Events arriving while busy go to the one-deep pending slot or are dropped.
      if (ev && stateReg != IDLE) begin
         if (pendValidReg) begin
            overflowNext = 1'b1;
         end else begin
            pendValidNext = 1'b1;
            pendDataNext  = bus.data;
            pendRsNext    = bus.rs;
         end
      end

      case (stateReg)
         PWR_WAIT: begin
            if (cntReg == LAST_PWR) begin
               cntNext     = '0;
               stateNext   = SETUP;
               initIdxNext = 3'd0;
               lcdRsNext   = 1'b0;
               lcdDbNext   = INIT_CMDS[0];
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         SETUP: begin
            if (cntReg == LAST_AS) begin
               cntNext   = '0;
               stateNext = E_HIGH;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         E_HIGH: begin
            if (cntReg == LAST_PW) begin
               cntNext   = '0;
               stateNext = HOLD;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         HOLD: begin
            if (cntReg == LAST_H) begin
               cntNext   = '0;
               stateNext = EXEC;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         EXEC: begin
            if (cntReg == execLast) begin
               cntNext   = '0;
               stateNext = SETUP;
               if (initIdxReg < LAST_IDX) begin
                  initIdxNext = initIdxReg + 3'd1;
                  lcdRsNext   = 1'b0;
                  lcdDbNext   = INIT_CMDS[initIdxReg + 3'd1];
               end else if (pendValidReg) begin
                  pendValidNext = 1'b0;
                  lcdRsNext     = pendRsReg;
                  lcdDbNext     = pendDataReg;
               end else if (ev) begin
                  // Event coinciding with completion is issued straight away.
                  pendValidNext = 1'b0;
                  lcdRsNext     = bus.rs;
                  lcdDbNext     = bus.data;
               end else begin
                  stateNext = IDLE;
               end
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         IDLE: begin
            if (ev) begin
               cntNext   = '0;
               stateNext = SETUP;
               lcdRsNext = bus.rs;
               lcdDbNext = bus.data;
            end
         end
         default: begin
            cntNext   = '0;
            stateNext = PWR_WAIT;
         end
      endcase

      lcdENext = (stateNext == E_HIGH);
   end

   assign bus.lcd_e    = lcdEReg;
   assign bus.lcd_rs   = lcdRsReg;
   assign bus.lcd_db   = lcdDbReg;
   assign bus.busy     = (stateReg != IDLE);
   assign bus.overflow = overflowReg;

endmodule

// File: tb/tb_lcd_write_fsm.sv
// Directed bench for lcd_write_fsm with T_POWERUP=10, T_EXEC_LONG=20, others default.
// Timing expectations are counted in clk edges from the stimulus change.
module tb_lcd_write_fsm;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;

   lcd_write_fsm_if bus ();

   lcd_write_fsm #(
      .T_POWERUP   (10),
      .T_EXEC_LONG (20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
      $display("[TB] check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Ticks until lcd_e is high; returns edges taken and bus values one cycle before.
   task automatic waitRise(output int n, output logic [7:0] pDb, output logic pRs, output logic pE);
      n = 0;
      do begin
         pDb = bus.lcd_db;
         pRs = bus.lcd_rs;
         pE  = bus.lcd_e;
         tick();
         n++;
      end while (bus.lcd_e !== 1'b1 && n < 6000);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (bus.busy !== 1'b0 && n < 6000) begin
         tick();
         n++;
      end
   endtask

   task automatic doLoad(input logic [7:0] d, input logic r, input int hi);
      bus.data = d;
      bus.rs   = r;
      bus.load = 1'b1;
      repeat (hi) tick();
      bus.load = 1'b0;
   endtask

   initial begin
      logic [7:0] initBytes [6];
      int         initExec [6];
      int         n, lastRise, r1, r2, rises;
      logic [7:0] pDb;
      logic       pRs, pE;

      initBytes = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      initExec  = '{100, 100, 100, 100, 20, 100};
      bus.load = 1'b0;
      bus.data = 8'h00;
      bus.rs   = 1'b0;
      lastRise = 0;

      // Reset state
      reset = 1'b1;
      tick();
      tick();
      chk("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
      chk("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
      chk("rst_lcd_db", 32'(bus.lcd_db), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd1);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      reset = 1'b0;

      // Init sequence: 10 power-up cycles, 1 setup, then E; rise-to-rise = exec + 3
      for (int i = 0; i < 6; i++) begin
         waitRise(n, pDb, pRs, pE);
         if (i == 0) chk("init_first_rise", 32'(n), 32'd11);
         else        chk($sformatf("init_period_%0d", i), 32'(cyc - lastRise), 32'(initExec[i-1] + 3));
         chk($sformatf("init_db_%0d", i), 32'(bus.lcd_db), 32'(initBytes[i]));
         chk($sformatf("init_rs_%0d", i), 32'(bus.lcd_rs), 32'd0);
         chk($sformatf("init_setup_db_%0d", i), 32'(pDb), 32'(initBytes[i]));
         chk($sformatf("init_busy_%0d", i), 32'(bus.busy), 32'd1);
         lastRise = cyc;
         tick();
         chk($sformatf("init_e_width_%0d", i), 32'(bus.lcd_e), 32'd0);
      end
      waitIdle();
      chk("init_busy_fall", 32'(cyc - lastRise), 32'd102);

      // Host write 0x41 rs=1: E rises 5 edges after load
      doLoad(8'h41, 1'b1, 2);
      waitRise(n, pDb, pRs, pE);
      chk("w41_latency", 32'(n + 2), 32'd5);
      chk("w41_db", 32'(bus.lcd_db), 32'h41);
      chk("w41_rs", 32'(bus.lcd_rs), 32'd1);
      chk("w41_setup_db", 32'(pDb), 32'h41);
      chk("w41_setup_rs", 32'(pRs), 32'd1);
      chk("w41_setup_e", 32'(pE), 32'd0);
      lastRise = cyc;
      tick();
      chk("w41_e_width", 32'(bus.lcd_e), 32'd0);
      waitIdle();
      chk("w41_busy_fall", 32'(cyc - lastRise), 32'd102);

      // Clear command uses the long wait; same byte as data uses the normal wait
      doLoad(8'h01, 1'b0, 2);
      waitRise(n, pDb, pRs, pE);
      chk("clr_db", 32'(bus.lcd_db), 32'h01);
      lastRise = cyc;
      waitIdle();
      chk("clr_exec_long", 32'(cyc - lastRise), 32'd22);
      doLoad(8'h01, 1'b1, 2);
      waitRise(n, pDb, pRs, pE);
      chk("data01_rs", 32'(bus.lcd_rs), 32'd1);
      lastRise = cyc;
      waitIdle();
      chk("data01_exec_short", 32'(cyc - lastRise), 32'd102);

      // Pending and overflow
      doLoad(8'h41, 1'b1, 2);
      waitRise(n, pDb, pRs, pE);
      r1 = cyc;
      tick();
      doLoad(8'h42, 1'b1, 2);
      repeat (4) tick();
      chk("pend_overflow_clear", 32'(bus.overflow), 32'd0);
      doLoad(8'h43, 1'b1, 2);
      repeat (4) tick();
      chk("drop_overflow_set", 32'(bus.overflow), 32'd1);
      waitRise(n, pDb, pRs, pE);
      chk("pend_db", 32'(bus.lcd_db), 32'h42);
      chk("pend_period", 32'(cyc - r1), 32'd103);
      r2 = cyc;
      rises = 0;
      pE = bus.lcd_e;
      while (bus.busy === 1'b1 && cyc - r2 < 3000) begin
         tick();
         if (bus.lcd_e === 1'b1 && pE === 1'b0) rises++;
         pE = bus.lcd_e;
      end
      chk("drop_no_extra_write", 32'(rises), 32'd0);
      chk("drop_busy_fall", 32'(cyc - r2), 32'd102);
      chk("drop_db_last", 32'(bus.lcd_db), 32'h42);
      chk("overflow_sticky", 32'(bus.overflow), 32'd1);

      // Reset while E is high
      doLoad(8'h41, 1'b1, 2);
      waitRise(n, pDb, pRs, pE);
      reset = 1'b1;
      tick();
      chk("midrst_lcd_e", 32'(bus.lcd_e), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd1);
      chk("midrst_overflow", 32'(bus.overflow), 32'd0);
      chk("midrst_db", 32'(bus.lcd_db), 32'h00);
      reset = 1'b0;
      waitRise(n, pDb, pRs, pE);
      chk("replay_first_rise", 32'(n), 32'd11);
      chk("replay_db", 32'(bus.lcd_db), 32'h38);
      waitIdle();
      chk("replay_done", 32'(bus.busy), 32'd0);

      // Load held high for 50 cycles issues one write
      bus.data = 8'h55;
      bus.rs   = 1'b1;
      bus.load = 1'b1;
      rises = 0;
      pE = bus.lcd_e;
      for (int i = 0; i < 250; i++) begin
         if (i == 50) bus.load = 1'b0;
         tick();
         if (bus.lcd_e === 1'b1 && pE === 1'b0) rises++;
         pE = bus.lcd_e;
      end
      chk("long_load_one_write", 32'(rises), 32'd1);
      chk("long_load_db", 32'(bus.lcd_db), 32'h55);
      chk("long_load_idle", 32'(bus.busy), 32'd0);
      chk("long_load_overflow", 32'(bus.overflow), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
